// File: rtl/stark_branch_issue_sched_pkg.sv
// Shared types and default sizing for the branch-station issue scheduler.
package stark_branch_issue_sched_pkg;

  localparam int BIS_NROB    = 16;
  localparam int BIS_NBS     = 2;
  localparam int BIS_ARG_TMO = 15;

  typedef logic [$clog2(BIS_NROB)-1:0] rob_ndx_t;

  typedef enum logic [1:0] {
    BSS_IDLE = 2'd0,
    BSS_WAIT = 2'd1,
    BSS_EXEC = 2'd2
  } bs_sched_state_t;

endpackage

// File: rtl/stark_branch_issue_sched_if.sv
// ROB/station-facing bundle of the branch issue scheduler.
interface stark_branch_issue_sched_if #(
  parameter int NROB = stark_branch_issue_sched_pkg::BIS_NROB,
  parameter int NBS  = stark_branch_issue_sched_pkg::BIS_NBS
);
  // issue is a one-cycle strobe with no back-pressure: only an IDLE station is ever
  // targeted, so the station whose bs_sel_oh bit is set must accept; rndxv mirrors issue.
  logic                                                 flush;
  logic [$clog2(NROB)-1:0]                              head;
  logic [NROB-1:0]                                      br_rdy;
  logic [NBS-1:0]                                       bs_argv;
  logic [NBS-1:0]                                       bs_done;
  logic                                                 issue;
  logic [$clog2(NROB)-1:0]                              rndx;
  logic                                                 rndxv;
  logic [NBS-1:0]                                       bs_sel_oh;
  logic                                                 replay;
  logic [$clog2(NROB)-1:0]                              replay_ndx;
  logic [$clog2(NBS):0]                                 busy_cnt;
  stark_branch_issue_sched_pkg::bs_sched_state_t [NBS-1:0] bs_state;

  modport master (
    output flush, head, br_rdy, bs_argv, bs_done,
    input  issue, rndx, rndxv, bs_sel_oh, replay, replay_ndx, busy_cnt, bs_state
  );

  modport slave (
    input  flush, head, br_rdy, bs_argv, bs_done,
    output issue, rndx, rndxv, bs_sel_oh, replay, replay_ndx, busy_cnt, bs_state
  );
endinterface

// File: rtl/stark_oldest_pick.sv
// Picks the oldest set request relative to a circular head pointer (N must be a power of 2).
module stark_oldest_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] head,
  output logic [$clog2(N)-1:0] ndx,
  output logic                 v
);
  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  always_comb begin
    rot = '0;
    off = '0;
    v   = 1'b0;
    for (int i = 0; i < N; i++) rot[i] = req[W'(i) + head];
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = W'(i);
        v   = 1'b1;
      end
    end
    ndx = off + head;
  end
endmodule

// File: rtl/stark_branch_issue_sched.sv
// Branch-station issue scheduler: oldest-ready pick, round-robin station steering,
// per-station argument timeout with replay, and flush drain.
module stark_branch_issue_sched
  import stark_branch_issue_sched_pkg::*;
#(
  parameter int NROB    = BIS_NROB,
  parameter int NBS     = BIS_NBS,
  parameter int ARG_TMO = BIS_ARG_TMO
) (
  input logic                       clk,
  input logic                       rst,
  stark_branch_issue_sched_if.slave bus
);
  localparam int RW = $clog2(NROB);
  localparam int SW = (NBS > 1) ? $clog2(NBS) : 1;
  localparam int CW = $clog2(NBS) + 1;
  localparam logic [7:0] TMO = 8'(ARG_TMO);

  logic [NROB-1:0]          issued_q, issued_d, cand;
  logic [RW-1:0]            pick_ndx;
  logic                     pick_v, do_issue, found;
  int                       tgt;
  logic [NBS-1:0]           idle_v, sel, tmo_v, fin_v, busy_nx;
  logic [NBS-1:0]           pnd_q, pnd_d;
  logic [NBS-1:0][RW-1:0]   own_all, pnd_ndx_q, pnd_ndx_d;
  bs_sched_state_t [NBS-1:0] st_all;
  logic [SW-1:0]            rr_q, rr_d;
  logic                     rp_v;
  logic [RW-1:0]            rp_ndx;
  logic [CW-1:0]            busy_d, busy_q;
  logic                     issue_q, replay_q;
  logic [RW-1:0]            rndx_q, replay_ndx_q;
  logic [NBS-1:0]           sel_q;

  assign cand = bus.br_rdy & ~issued_q;

  stark_oldest_pick #(.N(NROB)) u_pick (
    .req  (cand),
    .head (bus.head),
    .ndx  (pick_ndx),
    .v    (pick_v)
  );

  // Only stations already IDLE at the start of the cycle are eligible targets.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    tgt   = 0;
    for (int k = 0; k < NBS; k++) begin
      if (!found && idle_v[(int'(rr_q) + k) % NBS]) begin
        found = 1'b1;
        tgt   = (int'(rr_q) + k) % NBS;
      end
    end
    do_issue = pick_v && found && !bus.flush;
    if (do_issue) sel[tgt] = 1'b1;
  end

  assign rr_d = do_issue ? SW'((tgt + 1) % NBS) : rr_q;

  for (genvar b = 0; b < NBS; b++) begin : g_bs
    bs_sched_state_t st_q, st_d;
    logic [7:0]      tmr_q, tmr_d;
    logic [RW-1:0]   own_q, own_d;
    logic            tmo, fin;

    always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      own_d = own_q;
      tmo   = 1'b0;
      fin   = 1'b0;
      case (st_q)
        BSS_IDLE: if (sel[b]) begin
          st_d  = BSS_WAIT;
          tmr_d = '0;
          own_d = pick_ndx;
        end
        BSS_WAIT: begin
          if (bus.bs_argv[b]) st_d = BSS_EXEC;
          else if (tmr_q == TMO) begin
            st_d = BSS_IDLE;
            tmo  = 1'b1;
          end else tmr_d = tmr_q + 8'd1;
        end
        BSS_EXEC: if (bus.bs_done[b]) begin
          st_d = BSS_IDLE;
          fin  = 1'b1;
        end
        default: st_d = BSS_IDLE;
      endcase
      if (bus.flush) begin
        st_d  = BSS_IDLE;
        tmr_d = '0;
        tmo   = 1'b0;
        fin   = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= BSS_IDLE;
        tmr_q <= '0;
        own_q <= '0;
      end else begin
        st_q  <= st_d;
        tmr_q <= tmr_d;
        own_q <= own_d;
      end
    end

    assign idle_v[b]  = (st_q == BSS_IDLE);
    assign tmo_v[b]   = tmo;
    assign fin_v[b]   = fin;
    assign busy_nx[b] = (st_d != BSS_IDLE);
    assign own_all[b] = own_q;
    assign st_all[b]  = st_q;
  end

  // A timeout that loses replay arbitration parks in its station's pending slot.
  always_comb begin
    issued_d  = issued_q;
    pnd_d     = pnd_q | tmo_v;
    pnd_ndx_d = pnd_ndx_q;
    rp_v      = 1'b0;
    rp_ndx    = '0;
    busy_d    = '0;
    for (int b = 0; b < NBS; b++) begin
      if (tmo_v[b] || fin_v[b]) issued_d[own_all[b]] = 1'b0;
      if (tmo_v[b]) pnd_ndx_d[b] = own_all[b];
      busy_d = busy_d + CW'(busy_nx[b]);
    end
    for (int b = 0; b < NBS; b++) begin
      if (!rp_v && pnd_d[b]) begin
        rp_v     = 1'b1;
        rp_ndx   = pnd_ndx_d[b];
        pnd_d[b] = 1'b0;
      end
    end
    if (do_issue) issued_d[pick_ndx] = 1'b1;
    if (bus.flush) begin
      issued_d = '0;
      pnd_d    = '0;
      rp_v     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q     <= '0;
      pnd_q        <= '0;
      pnd_ndx_q    <= '0;
      rr_q         <= '0;
      issue_q      <= 1'b0;
      rndx_q       <= '0;
      sel_q        <= '0;
      replay_q     <= 1'b0;
      replay_ndx_q <= '0;
      busy_q       <= '0;
    end else begin
      issued_q  <= issued_d;
      pnd_q     <= pnd_d;
      pnd_ndx_q <= pnd_ndx_d;
      rr_q      <= rr_d;
      issue_q   <= do_issue;
      sel_q     <= sel;
      replay_q  <= rp_v;
      busy_q    <= busy_d;
      if (do_issue) rndx_q <= pick_ndx;
      if (rp_v) replay_ndx_q <= rp_ndx;
    end
  end

  assign bus.issue      = issue_q;
  assign bus.rndxv      = issue_q;
  assign bus.rndx       = rndx_q;
  assign bus.bs_sel_oh  = sel_q;
  assign bus.replay     = replay_q;
  assign bus.replay_ndx = replay_ndx_q;
  assign bus.busy_cnt   = busy_q;
  assign bus.bs_state   = st_all;
endmodule
